// File: rtl/spi_pkg.sv
// Shared types and frame constants for the SPI register-access controller.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } spi_state_e;

    localparam int FRAME_BITS = 16;
    localparam int CMD_BITS   = 8;
    localparam int DATA_BITS  = FRAME_BITS - CMD_BITS;
    localparam int RW_BIT     = 7;
    localparam int EDGE_COUNT = 2 * FRAME_BITS;
    localparam int EDGE_CNT_W = $clog2(EDGE_COUNT);
    localparam int DIV_CNT_W  = 8;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period divider: ticks every CLK_DIV cycles while enabled and splits
// ticks into alternating leading/trailing SPI edge strobes during shifting.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic shift,
    output logic tick,
    output logic lead,
    output logic trail
);

    logic [DIV_CNT_W-1:0] div_cnt;
    logic                 phase;

    assign tick  = en && (div_cnt == DIV_CNT_W'(CLK_DIV - 1));
    assign lead  = tick && shift && !phase;
    assign trail = tick && shift && phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            phase   <= 1'b0;
        end else begin
            if (!en || tick) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DIV_CNT_W'(1);
            end
            // phase 0 means the next shift tick moves spi_clk away from cpol
            if (!shift) begin
                phase <= 1'b0;
            end else if (tick) begin
                phase <= ~phase;
            end
        end
    end

endmodule

// File: rtl/spi_controller.sv
// SPI master issuing 16-bit register frames {rw, pad, addr, data}, MSB first,
// in any of the four cpol/cpha modes, with a CLK_DIV-cycle CS-high gap.
module spi_controller
    import spi_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int ADDR_WIDTH = 3,
    parameter int REG_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            mode,
    input  logic                  start,
    input  logic                  rw,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [REG_WIDTH-1:0]  wdata,
    output logic                  ready,
    output logic                  done,
    output logic [REG_WIDTH-1:0]  rdata,
    output logic                  spi_cs_n,
    output logic                  spi_clk,
    output logic                  spi_mosi,
    input  logic                  spi_miso
);

    spi_state_e            state, state_next;
    logic                  cpha_q;
    logic                  hold_late;
    logic [EDGE_CNT_W-1:0] edge_cnt;
    logic [FRAME_BITS-1:0] tx_shift;
    logic [REG_WIDTH-1:0]  rx_shift;
    logic [CMD_BITS-1:0]   cmd_byte;
    logic [DATA_BITS-1:0]  data_byte;
    logic [FRAME_BITS-1:0] frame_word;
    logic                  accept, cs_rise, go_idle;
    logic                  tick, lead, trail, adv, smp;

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk   (clk),
        .rst   (rst),
        .en    (state != IDLE),
        .shift (state == SHIFT),
        .tick  (tick),
        .lead  (lead),
        .trail (trail)
    );

    // cpha=0 samples on leading edges and advances on trailing; cpha=1 is the reverse
    assign adv = cpha_q ? lead : trail;
    assign smp = cpha_q ? trail : lead;

    always_comb begin
        cmd_byte                 = '0;
        cmd_byte[RW_BIT]         = rw;
        cmd_byte[ADDR_WIDTH-1:0] = addr;
        data_byte                = '0;
        if (rw) begin
            data_byte = DATA_BITS'(wdata);
        end
        frame_word = {cmd_byte, data_byte};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        cs_rise    = 1'b0;
        go_idle    = 1'b0;
        case (state)
            IDLE: begin
                if (start && ready) begin
                    state_next = SETUP;
                    accept     = 1'b1;
                end
            end
            SETUP: begin
                if (tick) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (tick && edge_cnt == EDGE_CNT_W'(EDGE_COUNT - 1)) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                // first tick ends the frame, second tick ends the CS-high gap
                if (tick) begin
                    if (hold_late) begin
                        state_next = IDLE;
                        go_idle    = 1'b1;
                    end else begin
                        cs_rise = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spi_cs_n  <= 1'b1;
            spi_clk   <= 1'b0;
            spi_mosi  <= 1'b0;
            ready     <= 1'b1;
            done      <= 1'b0;
            rdata     <= '0;
            cpha_q    <= 1'b0;
            edge_cnt  <= '0;
            hold_late <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                cpha_q   <= mode[0];
                spi_cs_n <= 1'b0;
                ready    <= 1'b0;
                spi_clk  <= mode[1];
                spi_mosi <= mode[0] ? 1'b0 : frame_word[FRAME_BITS-1];
            end else if (state == IDLE) begin
                spi_clk  <= mode[1];
                spi_mosi <= 1'b0;
            end
            if (lead || trail) begin
                spi_clk <= ~spi_clk;
            end
            if (adv) begin
                spi_mosi <= tx_shift[FRAME_BITS-1];
            end
            if (cs_rise) begin
                spi_cs_n <= 1'b1;
                spi_mosi <= 1'b0;
                done     <= 1'b1;
                rdata    <= rx_shift;
            end
            if (go_idle) begin
                ready <= 1'b1;
            end
            if (state != SHIFT) begin
                edge_cnt <= '0;
            end else if (tick) begin
                edge_cnt <= edge_cnt + EDGE_CNT_W'(1);
            end
            if (state != HOLD) begin
                hold_late <= 1'b0;
            end else if (tick) begin
                hold_late <= 1'b1;
            end
        end
    end

    // with cpha=0 bit 15 is already on MOSI, so the shifter starts one bit ahead
    always_ff @(posedge clk) begin
        if (accept) begin
            tx_shift <= mode[0] ? frame_word : (frame_word << 1);
        end else if (adv) begin
            tx_shift <= tx_shift << 1;
        end
        if (smp) begin
            rx_shift <= {rx_shift[REG_WIDTH-2:0], spi_miso};
        end
    end

endmodule
